// File: rtl/jtframe_rst_seq.sv
// Reset sequencer: waits for a stable PLL lock, then releases the per-domain resets one
// after another. It re-enters the sequence on lock loss, soft reset requests or lock timeout.
//
// state     | meaning
// WAIT_LOCK | all resets held; counting stable lock cycles and total time in state
// PLL_RST   | pll_rst pulsed for PLLRST_CYC cycles
// RELEASE   | channels released one by one, STAGGER cycles apart
// HOLD      | soft reset held for at least MIN_HOLD cycles and until rst_req drops
// RUN       | all domains out of reset
module jtframe_rst_seq #(
    parameter int CHANNELS    = 3,
    parameter int LOCK_STABLE = 255,
    parameter int PLLRST_CYC  = 255,
    parameter int STAGGER     = 16,
    parameter int TIMEOUT     = 65535,
    parameter int MIN_HOLD    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                rst_req,
    output logic                pll_rst,
    output logic [CHANNELS-1:0] rst_out,
    output logic [CHANNELS-1:0] rst_out_n,
    output logic                busy,
    output logic                relock_err
);

    localparam int REL_SPAN = (CHANNELS - 1) * STAGGER;
    localparam int MAX_A    = (TIMEOUT > PLLRST_CYC) ? TIMEOUT : PLLRST_CYC;
    localparam int MAX_B    = (LOCK_STABLE > REL_SPAN) ? LOCK_STABLE : REL_SPAN;
    localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAXV     = (MAX_C > MIN_HOLD) ? MAX_C : MIN_HOLD;
    localparam int CW       = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

    // Terminal-count values: the transition happens on the edge ending the cycle at *_LAST.
    localparam logic [CW-1:0] LS_LAST  = CW'((LOCK_STABLE < 1) ? 0 : LOCK_STABLE - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] PR_LAST  = CW'((PLLRST_CYC < 1) ? 0 : PLLRST_CYC - 1);
    localparam logic [CW-1:0] MH_LAST  = CW'((MIN_HOLD < 1) ? 0 : MIN_HOLD - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(REL_SPAN);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_PLL_RST,
        S_RELEASE,
        S_HOLD,
        S_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         tot_q, tot_d;
    logic                  sync1_q, lk_q, lkd_q;
    logic                  pll_rst_q, pll_rst_d;
    logic [CHANNELS-1:0]   rst_out_q, rst_out_d;
    logic [CHANNELS-1:0]   rst_out_n_q;
    logic                  busy_q, busy_d;
    logic                  relock_err_q, relock_err_d;
    logic                  lock_loss;

    assign lock_loss = lkd_q & ~lk_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tot_d        = tot_q;
        pll_rst_d    = pll_rst_q;
        rst_out_d    = rst_out_q;
        relock_err_d = relock_err_q;
        case (state_q)
            S_WAIT_LOCK: begin
                rst_out_d = '1;
                pll_rst_d = 1'b0;
                tot_d     = tot_q + 1'b1;
                cnt_d     = lk_q ? cnt_q + 1'b1 : '0;
                if (lk_q && cnt_q == LS_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    tot_d   = '0;
                end else if (tot_q == TO_LAST) begin
                    state_d      = S_PLL_RST;
                    pll_rst_d    = 1'b1;
                    relock_err_d = 1'b1;
                    cnt_d        = '0;
                    tot_d        = '0;
                end
            end
            S_PLL_RST: begin
                rst_out_d = '1;
                if (cnt_q == PR_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    cnt_d     = '0;
                    tot_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE, S_RUN: begin
                if (lock_loss) begin
                    state_d   = S_PLL_RST;
                    rst_out_d = '1;
                    pll_rst_d = 1'b1;
                    cnt_d     = '0;
                end else if (rst_req) begin
                    state_d   = S_HOLD;
                    rst_out_d = '1;
                    cnt_d     = '0;
                end else if (state_q == S_RELEASE) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        if (int'(cnt_q) == k * STAGGER) rst_out_d[k] = 1'b0;
                    end
                    if (cnt_q == REL_LAST) state_d = S_RUN;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    rst_out_d = '0;
                end
            end
            S_HOLD: begin
                rst_out_d = '1;
                if (lock_loss) begin
                    state_d   = S_PLL_RST;
                    pll_rst_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == MH_LAST && !rst_req) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q != MH_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_WAIT_LOCK;
                rst_out_d = '1;
                pll_rst_d = 1'b0;
                cnt_d     = '0;
                tot_d     = '0;
            end
        endcase
        busy_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT_LOCK;
            cnt_q        <= '0;
            tot_q        <= '0;
            sync1_q      <= 1'b0;
            lk_q         <= 1'b0;
            lkd_q        <= 1'b0;
            pll_rst_q    <= 1'b0;
            rst_out_q    <= '1;
            rst_out_n_q  <= '0;
            busy_q       <= 1'b1;
            relock_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tot_q        <= tot_d;
            sync1_q      <= pll_locked;
            lk_q         <= sync1_q;
            lkd_q        <= lk_q;
            pll_rst_q    <= pll_rst_d;
            rst_out_q    <= rst_out_d;
            rst_out_n_q  <= ~rst_out_d;
            busy_q       <= busy_d;
            relock_err_q <= relock_err_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign rst_out    = rst_out_q;
    assign rst_out_n  = rst_out_n_q;
    assign busy       = busy_q;
    assign relock_err = relock_err_q;

endmodule
